// File: rtl/bls12_381_pkg.sv
// Shared BLS12-381 base-field definitions: element type and modulus.
package bls12_381_pkg;

    localparam int FE_BITS  = 381;
    localparam int MOD_BITS = 6;

    typedef logic [FE_BITS-1:0] fe_t;

    localparam fe_t P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

endpackage

// File: rtl/bls12_381_fe_inv_server_fe_bin_gcd_step.sv
// One step of the binary extended Euclid used for Fp inversion.
// Purely combinational; the caller registers (u, v, x1, x2) every clock.
// Invariants kept: x1*a == u and x2*a == v (mod P), x1/x2 in [0, P).
module fe_bin_gcd_step
    import bls12_381_pkg::*;
#(
    parameter fe_t P = bls12_381_pkg::P
) (
    input  logic [FE_BITS-1:0] u_i,
    input  logic [FE_BITS-1:0] v_i,
    input  logic [FE_BITS-1:0] x1_i,
    input  logic [FE_BITS-1:0] x2_i,
    output logic [FE_BITS-1:0] u_o,
    output logic [FE_BITS-1:0] v_o,
    output logic [FE_BITS-1:0] x1_o,
    output logic [FE_BITS-1:0] x2_o,
    output logic               u_one_o,
    output logic               v_one_o
);

    localparam logic [FE_BITS:0] P_EXT = {1'b0, P};

    // x/2 mod P: odd x gets +P first so the sum is even (P is odd).
    function automatic fe_t half_mod(input fe_t x);
        return fe_t'(({1'b0, x} + (x[0] ? P_EXT : '0)) >> 1);
    endfunction

    // a-b mod P with both operands already reduced; one +P corrects a borrow.
    function automatic fe_t sub_mod(input fe_t a, input fe_t b);
        logic [FE_BITS:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[FE_BITS]) begin
            d = d + P_EXT;
        end
        return d[FE_BITS-1:0];
    endfunction

    assign u_one_o = (u_i == fe_t'(1));
    assign v_one_o = (v_i == fe_t'(1));

    // Priority-ordered reduction; holds the state once a terminal value is reached.
    always_comb begin
        u_o  = u_i;
        v_o  = v_i;
        x1_o = x1_i;
        x2_o = x2_i;
        if (u_one_o || v_one_o) begin
            u_o = u_i;
        end else if (!u_i[0]) begin
            u_o  = u_i >> 1;
            x1_o = half_mod(x1_i);
        end else if (!v_i[0]) begin
            v_o  = v_i >> 1;
            x2_o = half_mod(x2_i);
        end else if (u_i >= v_i) begin
            u_o  = u_i - v_i;
            x1_o = sub_mod(x1_i, x2_i);
        end else begin
            v_o  = v_i - u_i;
            x2_o = sub_mod(x2_i, x1_i);
        end
    end

endmodule

// File: rtl/bls12_381_fe_inv_server.sv
// Fp inversion responder: accepts a, returns a^-1 mod P with ctl echoed.
// One operation in flight; one Euclid step per clock.
//
// state | meaning
// IDLE  | ready for a request (input rdy high)
// RUN   | iterating the binary extended Euclid
// DONE  | result presented, waiting for output rdy
module bls12_381_fe_inv_server
    import bls12_381_pkg::*;
#(
    parameter fe_t P        = bls12_381_pkg::P,
    parameter int  CTL_BITS = 84
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_inv_val,
    output logic                i_inv_rdy,
    input  logic [FE_BITS-1:0]  i_inv_dat,
    input  logic [CTL_BITS-1:0] i_inv_ctl,
    output logic                o_inv_val,
    input  logic                o_inv_rdy,
    output logic [FE_BITS-1:0]  o_inv_dat,
    output logic [CTL_BITS-1:0] o_inv_ctl,
    output logic                o_inv_sop,
    output logic                o_inv_eop,
    output logic                o_inv_err,
    output logic [MOD_BITS-1:0] o_inv_mod
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                rdy_q;
    fe_t                 u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
    fe_t                 dat_q, dat_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic                err_q, err_d;

    fe_t  u_nx, v_nx, x1_nx, x2_nx;
    logic u_one, v_one;

    fe_bin_gcd_step #(.P(P)) u_step (
        .u_i     (u_q),
        .v_i     (v_q),
        .x1_i    (x1_q),
        .x2_i    (x2_q),
        .u_o     (u_nx),
        .v_o     (v_nx),
        .x1_o    (x1_nx),
        .x2_o    (x2_nx),
        .u_one_o (u_one),
        .v_one_o (v_one)
    );

    // Input rdy is registered so it stays low through reset and has no path from output rdy.
    assign i_inv_rdy = rdy_q;
    assign o_inv_val = (state_q == DONE);
    assign o_inv_dat = dat_q;
    assign o_inv_ctl = ctl_q;
    assign o_inv_err = err_q;
    assign o_inv_sop = o_inv_val;
    assign o_inv_eop = o_inv_val;
    assign o_inv_mod = '0;

    // Next-state and datapath selection for the FSM.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        dat_d   = dat_q;
        ctl_d   = ctl_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (i_inv_val && rdy_q) begin
                    ctl_d = i_inv_ctl;
                    u_d   = i_inv_dat;
                    v_d   = P;
                    x1_d  = fe_t'(1);
                    x2_d  = '0;
                    if (i_inv_dat == '0) begin
                        // Zero has no inverse: report it without iterating.
                        dat_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (u_one) begin
                    dat_d   = x1_q;
                    state_d = DONE;
                end else if (v_one) begin
                    dat_d   = x2_q;
                    state_d = DONE;
                end else begin
                    u_d  = u_nx;
                    v_d  = v_nx;
                    x1_d = x1_nx;
                    x2_d = x2_nx;
                end
            end
            DONE: begin
                if (o_inv_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers; reset discards any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            dat_q   <= '0;
            ctl_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            dat_q   <= dat_d;
            ctl_q   <= ctl_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bls12_381_fe_inv_server.sv
// Directed bench for the Fp inversion responder.
module tb_bls12_381_fe_inv_server;
    import bls12_381_pkg::*;

    localparam int CB = 84;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_val, in_rdy;
    fe_t           in_dat;
    logic [CB-1:0] in_ctl;
    logic          out_val, out_rdy;
    fe_t           out_dat;
    logic [CB-1:0] out_ctl;
    logic          out_sop, out_eop, out_err;
    logic [MOD_BITS-1:0] out_mod;

    int errors = 0;
    int checks = 0;
    int beats  = 0;

    bls12_381_fe_inv_server #(.P(P), .CTL_BITS(CB)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_inv_val (in_val),
        .i_inv_rdy (in_rdy),
        .i_inv_dat (in_dat),
        .i_inv_ctl (in_ctl),
        .o_inv_val (out_val),
        .o_inv_rdy (out_rdy),
        .o_inv_dat (out_dat),
        .o_inv_ctl (out_ctl),
        .o_inv_sop (out_sop),
        .o_inv_eop (out_eop),
        .o_inv_err (out_err),
        .o_inv_mod (out_mod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_val && out_rdy) beats <= beats + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fe_t mulmod(input fe_t a, input fe_t b);
        logic [761:0] prod;
        prod = {381'b0, a} * {381'b0, b};
        prod = prod % {381'b0, P};
        return prod[380:0];
    endfunction

    // Issue one request and wait (bounded) for the result to be presented.
    task automatic send(input fe_t a, input logic [CB-1:0] c, output int lat);
        int n;
        n = 0;
        while (!in_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("in_rdy_wait", 384'(n < 200), 384'(1));
        in_val = 1'b1;
        in_dat = a;
        in_ctl = c;
        @(posedge clk); #1;
        in_val = 1'b0;
        in_dat = '0;
        lat = 1;
        while (!out_val && lat < 2000) begin
            @(posedge clk); #1; lat++;
        end
        check("out_val_wait", 384'(out_val), 384'(1));
    endtask

    task automatic take();
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
    endtask

    initial begin
        int            lat;
        int            b0;
        fe_t           snap;
        fe_t           a;
        fe_t           half;
        logic [383:0]  r;
        logic [95:0]   rc;
        logic [CB-1:0] c;

        in_val = 1'b0; in_dat = '0; in_ctl = '0; out_rdy = 1'b0;
        half = fe_t'(({1'b0, P} + 382'd1) >> 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy",  384'(in_rdy),  384'(0));
        check("rst_out_val", 384'(out_val), 384'(0));
        check("rst_dat",     384'(out_dat), 384'(0));
        check("rst_ctl",     384'(out_ctl), 384'(0));
        check("rst_err",     384'(out_err), 384'(0));
        check("rst_sop",     384'(out_sop), 384'(0));
        check("rst_eop",     384'(out_eop), 384'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_rdy",  384'(in_rdy),  384'(1));
        check("idle_out_val", 384'(out_val), 384'(0));

        // a = 1
        send(fe_t'(1), 84'h5A, lat);
        check("a1_lat", 384'(lat), 384'(2));
        check("a1_dat", 384'(out_dat), 384'(1));
        check("a1_ctl", 384'(out_ctl), 384'(84'h5A));
        check("a1_err", 384'(out_err), 384'(0));
        check("a1_sop", 384'(out_sop), 384'(1));
        check("a1_eop", 384'(out_eop), 384'(1));
        check("a1_mod", 384'(out_mod), 384'(0));
        check("a1_in_rdy_busy", 384'(in_rdy), 384'(0));
        b0 = beats;
        take();
        check("a1_val_drop", 384'(out_val), 384'(0));
        check("a1_beats", 384'(beats), 384'(b0 + 1));

        // a = 0
        send(fe_t'(0), 84'h3, lat);
        check("a0_lat", 384'(lat), 384'(1));
        check("a0_dat", 384'(out_dat), 384'(0));
        check("a0_err", 384'(out_err), 384'(1));
        check("a0_ctl", 384'(out_ctl), 384'(84'h3));
        take();

        // a = 2
        send(fe_t'(2), 84'h123, lat);
        check("a2_dat", 384'(out_dat), 384'(half));
        check("a2_err", 384'(out_err), 384'(0));
        check("a2_lat_bound", 384'(lat <= 1526), 384'(1));
        take();

        // a = P-1
        send(P - fe_t'(1), 84'hFEED, lat);
        check("apm1_dat", 384'(out_dat), 384'(P - fe_t'(1)));
        check("apm1_ctl", 384'(out_ctl), 384'(84'hFEED));
        check("apm1_lat_bound", 384'(lat <= 1526), 384'(1));
        take();

        // back-pressure
        send(fe_t'(5), 84'hABCDE, lat);
        snap = out_dat;
        check("bp_inverse", 384'(mulmod(fe_t'(5), snap)), 384'(1));
        b0 = beats;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_val",    384'(out_val), 384'(1));
            check("bp_dat",    384'(out_dat), 384'(snap));
            check("bp_ctl",    384'(out_ctl), 384'(84'hABCDE));
            check("bp_in_rdy", 384'(in_rdy),  384'(0));
        end
        check("bp_no_beat", 384'(beats), 384'(b0));
        take();
        check("bp_val_drop", 384'(out_val), 384'(0));
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_beat", 384'(beats), 384'(b0 + 1));

        // reset on cycle 20 of a run
        b0 = beats;
        in_val = 1'b1; in_dat = fe_t'(7); in_ctl = 84'h77;
        @(posedge clk); #1;
        in_val = 1'b0; in_dat = '0;
        repeat (19) @(posedge clk);
        #1;
        check("mid_still_running", 384'(out_val), 384'(0));
        rst_n = 1'b0;
        #2;
        check("mid_rst_val",    384'(out_val), 384'(0));
        check("mid_rst_in_rdy", 384'(in_rdy),  384'(0));
        check("mid_rst_dat",    384'(out_dat), 384'(0));
        #5;
        rst_n = 1'b1;
        out_rdy = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check("mid_no_stale_beat", 384'(beats),   384'(b0));
        check("mid_no_stale_val",  384'(out_val), 384'(0));
        check("mid_idle_in_rdy",   384'(in_rdy),  384'(1));
        send(fe_t'(3), 84'h33, lat);
        check("a3_inverse", 384'(mulmod(fe_t'(3), out_dat)), 384'(1));
        check("a3_ctl",     384'(out_ctl), 384'(84'h33));
        check("a3_err",     384'(out_err), 384'(0));
        take();

        // random operands with random output stalls
        for (int k = 0; k < 20; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            a = r[380:0] % P;
            if (a == '0) a = fe_t'(1);
            rc = {$urandom, $urandom, $urandom};
            c = rc[CB-1:0];
            send(a, c, lat);
            check("rnd_inverse", 384'(mulmod(a, out_dat)), 384'(1));
            check("rnd_ctl",     384'(out_ctl), 384'(c));
            check("rnd_err",     384'(out_err), 384'(0));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rnd_val_held", 384'(out_val), 384'(1));
            b0 = beats;
            take();
            check("rnd_beat", 384'(beats), 384'(b0 + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
